next_pc_predictor: RTL and testbench
====================================

Name: next_pc_predictor

Overview:
- Next-PC generation stage directly upstream of the PC register; drives its PC_Next input every cycle.
- Predicts conditional branches with a direct-mapped branch target buffer (BTB) holding 2-bit saturating counters.
- Applies ID-stage direct jumps (j/jal).
- Resolves predictions against the EX-stage outcome and raises a redirect/flush on mispredict.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, 4..64.
- IDX_W, log2(ENTRIES), index width; derived, not overridable.
- RESET_PC, 32'h00400000, value used in PC arithmetic sanity only; the PC register owns the actual reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- PC  in  32  current fetch PC (PC register output).
- PC4  in  32  PC+4 from the PC register.
- id_jump  in  1  ID stage decoded j/jal this cycle.
- id_jump_target  in  32  {PC_id[31:28], imm26, 2'b00}.
- ex_valid  in  1  EX holds a resolved branch/jr; pulses exactly once per instruction.
- ex_is_branch  in  1  EX instruction is a conditional branch (beq/bne/…); 0 means jr/jalr.
- ex_pc  in  32  PC of the EX instruction.
- ex_taken  in  1  actual branch outcome (1 for jr).
- ex_target  in  32  actual taken target.
- ex_pred_taken  in  1  prediction carried down the pipeline with this instruction.
- ex_pred_target  in  32  predicted target carried down the pipeline.
- PC_Next  out  32  next fetch address to the PC register.
- pred_taken  out  1  prediction for the current PC; travels with the instruction.
- pred_target  out  32  predicted target for the current PC.
- flush  out  1  mispredict; IF/ID and ID/EX must be cleared.
- mispredict_cnt  out  32  saturating count of mispredicts.

Behaviour:
- BTB entry fields: valid, tag = PC[31:IDX_W+2], target[31:0], ctr[1:0]. Index = PC[IDX_W+1:2].
- Lookup is combinational. hit = valid && tag match. pred_taken = hit && ctr[1]. pred_target = hit ? target : PC4.
- Mispredict is defined only when ex_valid:
  - actual taken ≠ ex_pred_taken, or
  - both taken and ex_target ≠ ex_pred_target.
- flush = that mispredict condition; it is combinational, same cycle.
- redirect = ex_taken ? ex_target : ex_pc+4.
- PC_Next priority, highest first:
  1. flush → redirect
  2. id_jump → id_jump_target
  3. pred_taken → pred_target
  4. otherwise PC4
- id_jump arriving in the same cycle as flush is discarded; it is on the wrong path.
- BTB update happens on the rising edge when ex_valid && ex_is_branch, indexed by ex_pc:
  - hit, taken: ctr saturating increment (max 3); target ← ex_target.
  - hit, not taken: ctr saturating decrement (min 0); target unchanged.
  - miss, taken: allocate. valid=1, tag, target=ex_target, ctr=2'b10.
  - miss, not taken: no change.
- jr/jalr (ex_is_branch=0) never update the BTB; they can still flush.
- Read-during-write to the same index: the lookup sees the old contents. The update is visible from the next cycle.
- mispredict_cnt increments by 1 on each clock edge where flush=1 and saturates at 32'hFFFFFFFF.
- Reset (async, any time, including mid-update):
  - all valid ← 0, all ctr ← 2'b01, targets/tags ← 0, mispredict_cnt ← 0.
  - Outputs after reset: pred_taken=0, pred_target=PC4, flush=0 (assuming ex_valid=0), PC_Next=PC4.
- Stalls: this block has no Keep input. The hazard unit must deassert the PC register's Keep whenever flush=1, so that the redirect is never lost. The EX stage must hold ex_valid low while EX is stalled, so each instruction updates exactly once.
- All address arithmetic is modulo 2^32; ex_pc+4 wraps from 32'hFFFFFFFC to 0.

Decomposition:
- Shared package holds:
  - CTR_WEAK_T = 2'b10, CTR_WEAK_NT = 2'b01, CTR_MAX = 2'b11, CTR_MIN = 2'b00.
  - the default ENTRIES value.
- One sub-module, btb_table:
  - storage array, combinational read port, registered write port, async clear.
  - the predictor wraps it with the redirect, priority and counter logic.

Test Plan:
- Reset then PC=32'h00400000, no ex/id activity → PC_Next=32'h00400004, pred_taken=0, flush=0, mispredict_cnt=0.
- Branch at ex_pc=32'h00400010 resolved taken to 32'h00400040, ex_pred_taken=0 → flush=1, PC_Next=32'h00400040. Then PC=32'h00400010 → pred_taken=1, PC_Next=32'h00400040. mispredict_cnt=1.
- Same branch resolved not-taken twice with correct prediction tracking:
  - first resolution: ctr 10→01, flush=1, PC_Next=32'h00400014.
  - next lookup: pred_taken=0.
  - second resolution: ctr 01→00 (saturates at 0 on further resolutions).
- Aliasing: PC=32'h00400050 shares an index with 32'h00400010 but has a different tag → pred_taken=0. Allocating 32'h00400050 evicts the 32'h00400010 entry.
- Simultaneous flush and id_jump=1 (target 32'h00400100) → PC_Next=redirect, not 32'h00400100. With id_jump alone → PC_Next=32'h00400100.
- Assert rst mid-cycle while ex_valid update is pending → BTB cleared immediately, no write lands. A subsequent lookup of the previously allocated PC → pred_taken=0.

Source files
------------

// File: rtl/next_pc_predictor_pkg.sv
// Shared constants and helpers for the next-PC predictor.
// The saturating counter policy for BTB entries lives here.
package next_pc_predictor_pkg;

  localparam int DEFAULT_ENTRIES = 16;

  localparam logic [1:0] CTR_WEAK_T  = 2'b10;
  localparam logic [1:0] CTR_WEAK_NT = 2'b01;
  localparam logic [1:0] CTR_MAX     = 2'b11;
  localparam logic [1:0] CTR_MIN     = 2'b00;

  typedef enum logic [1:0] {
    SRC_PC4,
    SRC_PRED,
    SRC_JUMP,
    SRC_REDIRECT
  } pc_src_e;

  function automatic logic [1:0] ctr_next(
    input logic [1:0] ctr,
    input logic       taken
  );
    logic [1:0] r;
    r = ctr;
    if (taken) begin
      if (ctr != CTR_MAX) r = ctr + 2'd1;
    end else begin
      if (ctr != CTR_MIN) r = ctr - 2'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/next_pc_predictor_btb_table.sv
// Direct-mapped BTB storage: two combinational read ports,
// one registered write port, asynchronous clear.
module btb_table
  import next_pc_predictor_pkg::*;
#(
  parameter int ENTRIES = DEFAULT_ENTRIES,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = 30 - IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] a_idx,
  output logic             a_valid,
  output logic [TAG_W-1:0] a_tag,
  output logic [31:0]      a_target,
  output logic [1:0]       a_ctr,
  input  logic [IDX_W-1:0] b_idx,
  output logic             b_valid,
  output logic [TAG_W-1:0] b_tag,
  output logic [31:0]      b_target,
  output logic [1:0]       b_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_target,
  input  logic [1:0]       wr_ctr
);

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  // Reads see pre-edge contents; writes land on the clock edge.
  assign a_valid  = valid_q[a_idx];
  assign a_tag    = tag_q[a_idx];
  assign a_target = target_q[a_idx];
  assign a_ctr    = ctr_q[a_idx];

  assign b_valid  = valid_q[b_idx];
  assign b_tag    = tag_q[b_idx];
  assign b_target = target_q[b_idx];
  assign b_ctr    = ctr_q[b_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WEAK_NT;
      end
    end else if (wr_en) begin
      valid_q[wr_idx]  <= 1'b1;
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
      ctr_q[wr_idx]    <= wr_ctr;
    end
  end

endmodule

// File: rtl/next_pc_predictor.sv
// Next-PC generation: BTB prediction, ID jumps and EX
// mispredict redirect feeding the PC register.
module next_pc_predictor
  import next_pc_predictor_pkg::*;
#(
  parameter int          ENTRIES  = DEFAULT_ENTRIES,
  parameter logic [31:0] RESET_PC = 32'h00400000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  input  logic [31:0] PC4,
  input  logic        id_jump,
  input  logic [31:0] id_jump_target,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic [31:0] PC_Next,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic        flush,
  output logic [31:0] mispredict_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_valid;
  logic [TAG_W-1:0] f_tag_q;
  logic [31:0]      f_target;
  logic [1:0]       f_ctr;
  logic             f_hit;

  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_valid;
  logic [TAG_W-1:0] u_tag_q;
  logic [31:0]      u_target;
  logic [1:0]       u_ctr;
  logic             u_hit;

  logic             wr_en;
  logic [31:0]      wr_target;
  logic [1:0]       wr_ctr;
  logic [31:0]      redirect;
  pc_src_e          pc_src;

  // Byte-offset bits and the sanity PC carry no information here.
  logic unused_bits;
  assign unused_bits = ^{PC[1:0], ex_pc[1:0], RESET_PC[1:0]};

  assign f_idx = PC[IDX_W+1:2];
  assign f_tag = PC[31:IDX_W+2];
  assign u_idx = ex_pc[IDX_W+1:2];
  assign u_tag = ex_pc[31:IDX_W+2];

  btb_table #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W),
    .TAG_W   (TAG_W)
  ) u_btb (
    .clk       (clk),
    .rst       (rst),
    .a_idx     (f_idx),
    .a_valid   (f_valid),
    .a_tag     (f_tag_q),
    .a_target  (f_target),
    .a_ctr     (f_ctr),
    .b_idx     (u_idx),
    .b_valid   (u_valid),
    .b_tag     (u_tag_q),
    .b_target  (u_target),
    .b_ctr     (u_ctr),
    .wr_en     (wr_en),
    .wr_idx    (u_idx),
    .wr_tag    (u_tag),
    .wr_target (wr_target),
    .wr_ctr    (wr_ctr)
  );

  assign f_hit       = f_valid && (f_tag_q == f_tag);
  assign pred_taken  = f_hit && f_ctr[1];
  assign pred_target = f_hit ? f_target : PC4;

  assign flush = ex_valid &&
                 ((ex_taken != ex_pred_taken) ||
                  (ex_taken && ex_pred_taken &&
                   (ex_target != ex_pred_target)));

  assign redirect = ex_taken ? ex_target : ex_pc + 32'd4;

  // A miss that resolves not-taken leaves the table alone.
  assign u_hit = u_valid && (u_tag_q == u_tag);

  always_comb begin
    wr_en     = 1'b0;
    wr_target = ex_target;
    wr_ctr    = CTR_WEAK_T;
    if (ex_valid && ex_is_branch) begin
      if (u_hit) begin
        wr_en  = 1'b1;
        wr_ctr = ctr_next(u_ctr, ex_taken);
        if (!ex_taken) wr_target = u_target;
      end else if (ex_taken) begin
        wr_en = 1'b1;
      end
    end
  end

  // Wrong-path id_jump loses to a flush.
  always_comb begin
    pc_src = SRC_PC4;
    if (flush)           pc_src = SRC_REDIRECT;
    else if (id_jump)    pc_src = SRC_JUMP;
    else if (pred_taken) pc_src = SRC_PRED;
  end

  always_comb begin
    PC_Next = PC4;
    unique case (pc_src)
      SRC_REDIRECT: PC_Next = redirect;
      SRC_JUMP:     PC_Next = id_jump_target;
      SRC_PRED:     PC_Next = pred_target;
      SRC_PC4:      PC_Next = PC4;
      default:      PC_Next = PC4;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict_cnt <= '0;
    end else if (flush && (mispredict_cnt != 32'hFFFF_FFFF)) begin
      mispredict_cnt <= mispredict_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_next_pc_predictor.sv
// Randomized and directed bench for next_pc_predictor
// against a table-of-records reference model.
module tb_next_pc_predictor;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC, PC4;
  logic        id_jump;
  logic [31:0] id_jump_target;
  logic        ex_valid, ex_is_branch, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic [31:0] PC_Next;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        flush;
  logic [31:0] mispredict_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: one record per BTB slot.
  bit          m_valid [N];
  int unsigned m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];
  longint unsigned m_cnt;

  always #5 clk = ~clk;

  next_pc_predictor dut (
    .clk            (clk),
    .rst            (rst),
    .PC             (PC),
    .PC4            (PC4),
    .id_jump        (id_jump),
    .id_jump_target (id_jump_target),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .PC_Next        (PC_Next),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .flush          (flush),
    .mispredict_cnt (mispredict_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int m_idx(input logic [31:0] a);
    return int'((a / 4) % N);
  endfunction

  function automatic int unsigned m_tagof(input logic [31:0] a);
    return a / (4 * N);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[m_idx(a)] && (m_tag[m_idx(a)] == m_tagof(a));
  endfunction

  task automatic m_clear();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0;
      m_tag[i]   = 0;
      m_tgt[i]   = 0;
      m_ctr[i]   = 1;
    end
    m_cnt = 0;
  endtask

  // One cycle: drive, check combinational outputs, clock, update model.
  task automatic cycle(
    input logic [31:0] pc, input logic idj, input logic [31:0] idt,
    input logic ev, input logic eb, input logic [31:0] epc,
    input logic et, input logic [31:0] etg,
    input logic ept, input logic [31:0] eptg);
    bit          hit, p, mis;
    logic [31:0] ptgt, nxt;
    int          i;
    @(negedge clk);
    PC = pc; PC4 = pc + 32'd4;
    id_jump = idj; id_jump_target = idt;
    ex_valid = ev; ex_is_branch = eb; ex_pc = epc;
    ex_taken = et; ex_target = etg;
    ex_pred_taken = ept; ex_pred_target = eptg;
    #1;
    hit  = m_hit(pc);
    p    = hit && (m_ctr[m_idx(pc)] >= 2);
    ptgt = hit ? m_tgt[m_idx(pc)] : pc + 32'd4;
    mis  = ev && ((et != ept) || (et && etg != eptg));
    if (mis)      nxt = et ? etg : epc + 32'd4;
    else if (idj) nxt = idt;
    else if (p)   nxt = ptgt;
    else          nxt = pc + 32'd4;
    chk("pred_taken", {31'd0, pred_taken}, {31'd0, p});
    chk("pred_target", pred_target, ptgt);
    chk("flush", {31'd0, flush}, {31'd0, mis});
    chk("PC_Next", PC_Next, nxt);
    chk("mispredict_cnt", mispredict_cnt, m_cnt[31:0]);
    @(posedge clk);
    if (mis && m_cnt < 64'hFFFF_FFFF) m_cnt++;
    if (ev && eb) begin
      i = m_idx(epc);
      if (m_hit(epc)) begin
        if (et) begin
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_tgt[i] = etg;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (et) begin
        m_valid[i] = 1;
        m_tag[i]   = m_tagof(epc);
        m_tgt[i]   = etg;
        m_ctr[i]   = 2;
      end
    end
  endtask

  task automatic idle(input logic [31:0] pc);
    cycle(pc, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic br(input logic [31:0] pc, input logic [31:0] epc,
                    input logic et, input logic [31:0] etg,
                    input logic ept, input logic [31:0] eptg);
    cycle(pc, 0, 0, 1, 1, epc, et, etg, ept, eptg);
  endtask

  localparam logic [31:0] B  = 32'h00400010;
  localparam logic [31:0] BT = 32'h00400040;
  localparam logic [31:0] AL = 32'h00400050;

  initial begin
    logic [31:0] rpc, repc, rtg, rptg;
    logic        rt, rpt;
    m_clear();
    PC = 32'h00400000; PC4 = 32'h00400004;
    id_jump = 0; id_jump_target = 0;
    ex_valid = 0; ex_is_branch = 0; ex_pc = 0;
    ex_taken = 0; ex_target = 0;
    ex_pred_taken = 0; ex_pred_target = 0;
    rst = 1;
    #12;
    chk("rst_cnt", mispredict_cnt, 32'd0);
    chk("rst_pred", {31'd0, pred_taken}, 32'd0);
    @(negedge clk);
    rst = 0;

    idle(32'h00400000);
    // Allocate taken branch, then predict it.
    br(32'h00400000, B, 1, BT, 0, 0);
    idle(B);
    // Resolve not-taken three times: 10->01->00->00.
    br(B + 4, B, 0, 0, 1, BT);
    idle(B);
    br(B + 4, B, 0, 0, 0, 0);
    br(B + 4, B, 0, 0, 0, 0);
    br(B + 4, B, 1, BT, 0, 0);
    idle(B);
    // Aliasing slot: other tag misses, then evicts.
    br(32'h00400000, B, 1, BT, 0, 0);
    br(32'h00400000, B, 1, BT, 0, 0);
    idle(AL);
    idle(B);
    br(B, AL, 1, 32'h00400200, 0, 0);
    idle(B);
    idle(AL);
    // Target mismatch with both taken.
    br(AL, AL, 1, 32'h00400300, 1, 32'h00400200);
    idle(AL);
    // Flush beats id_jump; id_jump alone wins over PC4.
    cycle(B, 1, 32'h00400100, 1, 1, B, 1, BT, 0, 0);
    cycle(32'h00400000, 1, 32'h00400100, 0, 0, 0, 0, 0, 0, 0);
    // jr flushes but never allocates; wrap at top of memory.
    cycle(B, 0, 0, 1, 0, 32'h00400080, 1, 32'h00401000, 0, 0);
    idle(32'h00400080);
    br(B, 32'hFFFF_FFFC, 0, 0, 1, 32'h10);

    // Random traffic in a small address window to force hits.
    for (int n = 0; n < 400; n++) begin
      rpc  = 32'h00400000 + ($urandom_range(0, 31) << 2);
      repc = 32'h00400000 + ($urandom_range(0, 31) << 2);
      rtg  = 32'h00400000 + ($urandom_range(0, 255) << 2);
      rt   = 1'($urandom_range(0, 1));
      rpt  = 1'($urandom_range(0, 1));
      rptg = ($urandom_range(0, 1) != 0) ? rtg
           : 32'h00400000 + ($urandom_range(0, 255) << 2);
      cycle(rpc, 1'($urandom_range(0, 3) == 0),
            32'h00500000 + ($urandom_range(0, 63) << 2),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) != 0),
            repc, rt, rtg, rpt, rptg);
    end

    // Reset mid-cycle with an allocating update pending.
    br(32'h00400000, 32'h00400020, 1, 32'h00400400, 0, 0);
    idle(32'h00400020);
    @(negedge clk);
    PC = 32'h00400020; PC4 = 32'h00400024;
    ex_valid = 1; ex_is_branch = 1; ex_pc = 32'h00400034;
    ex_taken = 1; ex_target = 32'h00400500;
    ex_pred_taken = 0; ex_pred_target = 0;
    #1;
    chk("pre_rst_pred", {31'd0, pred_taken}, 32'd1);
    rst = 1;
    #1;
    chk("rst_mid_pred", {31'd0, pred_taken}, 32'd0);
    chk("rst_mid_cnt", mispredict_cnt, 32'd0);
    @(posedge clk);
    #1;
    m_clear();
    @(negedge clk);
    ex_valid = 0;
    rst = 0;
    idle(32'h00400034);
    idle(32'h00400020);
    idle(32'h00400000);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
